lsu_param: RTL and testbench
============================

// Module: lsu_param
// PURPOSE
//  Per-thread load-store unit, next generation: parametrised data/address width, true valid/ready
//  handshake (valid held until accepted), and an error outcome. Executes LDR/STR for one thread
//  lane; one instance per thread per core, between core scheduler/decoder and the memory controller.
//  Optional watchdog aborts hung requests.
// PARAMETERS
//  DATA_BITS       8    width of rs/rt/lsu_out and memory data buses
//  ADDR_BITS       8    memory address width; address = rs zero-extended or truncated to ADDR_BITS
//  TIMEOUT_CYCLES  64   max cycles in WAITING before abort (only with LSU_TIMEOUT_EN); >=1
// PORTS
//  clk                       in   1          clock, rising edge
//  reset                     in   1          async, active-low: reset==0 resets immediately
//  enable                    in   1          lane active; 0 aborts/holds IDLE
//  core_state                in   3          core pipeline state (REQUEST=3'b011, UPDATE=3'b110)
//  decoded_mem_read_enable   in   1          current instr is LDR
//  decoded_mem_write_enable  in   1          current instr is STR
//  rs                        in   DATA_BITS  address operand
//  rt                        in   DATA_BITS  store data operand
//  mem_read_valid            out  1          read request
//  mem_read_address          out  ADDR_BITS
//  mem_read_ready            in   1          read accepted, mem_read_data valid this cycle
//  mem_read_data             in   DATA_BITS
//  mem_write_valid           out  1          write request
//  mem_write_address         out  ADDR_BITS
//  mem_write_data            out  DATA_BITS
//  mem_write_ready           in   1          write accepted this cycle
//  lsu_state                 out  3          IDLE=0 REQUESTING=1 WAITING=2 DONE=3 ERROR=4
//  lsu_out                   out  DATA_BITS  loaded data
//  lsu_error                 out  1          last op failed (sticky until UPDATE)
// BEHAVIOUR
//  - Reset (reset==0, async): lsu_state=IDLE; all outputs 0.
//  - IDLE: if enable & core_state==REQUEST & exactly one of rd/wr enable -> REQUESTING.
//    Both rd and wr enable at REQUEST -> ERROR, no memory transaction. Neither -> stay IDLE.
//  - REQUESTING (1 cycle): latch address (and rt for STR), assert matching valid -> WAITING.
//  - WAITING: valid and address/data held stable until ready==1 sampled on an edge; on that edge
//    valid<=0, LDR: lsu_out<=mem_read_data; -> DONE. Ready while valid==0 ignored.
//  - DONE / ERROR: hold until core_state==UPDATE, then -> IDLE, lsu_error<=0.
//    lsu_out holds value until next LDR completes.
//  - Latency: REQUEST edge n -> valid high after edge n+1; ready at edge n+2 earliest -> DONE;
//    minimum 3 cycles REQUEST-to-DONE.
//  - enable==0 in any state: next edge -> IDLE, both valids 0, lsu_error 0 (abort; request dropped
//    un-accepted is legal for controller).
//  - rd/wr enable changing mid-op ignored; op type latched in REQUESTING.
//  - Only one valid ever high; never both.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: counter clears on entry to WAITING, increments each WAITING cycle
//    without ready; on reaching TIMEOUT_CYCLES: valid<=0, lsu_error<=1, lsu_out unchanged -> ERROR.
//    Ready on the same edge as timeout wins (normal completion).
//  LSU_TIMEOUT_EN undefined: no counter, WAITING waits indefinitely; lsu_error only from rd+wr
//    conflict.
// STRUCTURE
//  - lsu_pkg: lsu_state_t enum (3-bit), CORE_STATE_REQUEST=3'b011, CORE_STATE_UPDATE=3'b110.
//  - Sub-module lsu_watchdog (counter, clear/tick/expired), instantiated only under LSU_TIMEOUT_EN.
//  - Single FSM always_ff with async-low reset; one shared address/data register set.
// TESTING
//  1 LDR: rs=8'h2A, REQUEST; ready 2 cycles after valid, data=8'h5C -> read_address=8'h2A held,
//    lsu_out=8'h5C, DONE; UPDATE -> IDLE.
//  2 STR: rs=8'h10, rt=8'hA5, ready immediate -> one write, addr=8'h10 data=8'hA5, valid drops
//    same edge as ready.
//  3 Conflict: rd+wr enable at REQUEST -> ERROR, lsu_error=1, no valid ever high; UPDATE clears.
//  4 Abort: enable->0 in WAITING -> IDLE next edge, valid=0; ready then ignored, lsu_out unchanged.
//  5 Async reset: reset low mid-WAITING between edges -> outputs 0 immediately.
//  6 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never -> ERROR after 4 WAITING cycles, lsu_error=1;
//    variant: ready on the 4th edge -> DONE, no error.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the per-thread load-store unit.
//   lsu_state_t        : 3-bit LSU FSM encoding, visible on lsu_param.lsu_state
//   CORE_STATE_REQUEST : core pipeline state in which a new LDR/STR is issued
//   CORE_STATE_UPDATE  : core pipeline state that retires a finished/failed op
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE       = 3'd0,
    LSU_REQUESTING = 3'd1,
    LSU_WAITING    = 3'd2,
    LSU_DONE       = 3'd3,
    LSU_ERROR      = 3'd4
  } lsu_state_t;

  localparam logic [2:0] CORE_STATE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_STATE_UPDATE  = 3'b110;

endpackage

// File: rtl/lsu_watchdog.sv
// Wait-cycle watchdog for the LSU. Built only when LSU_TIMEOUT_EN is defined.
//   clk, reset : clock / async active-low reset
//   clear      : restart the count (asserted on the cycle before WAITING)
//   tick       : one WAITING cycle passed without the memory accepting
//   expired    : this is the TIMEOUT_CYCLES-th WAITING cycle without ready;
//                the LSU aborts on the coming edge unless ready arrives
module lsu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (tick)   cnt <= cnt + 1'b1;
  end

  // cnt counts earlier stalled cycles, so the current cycle is number cnt+1
  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lsu_param.sv
// Per-thread load-store unit with valid/ready memory handshake.
// Executes one LDR or STR per REQUEST from the core; result/error held until
// the core reaches UPDATE.
//   clk, reset                : clock / async active-low reset
//   enable                    : lane active; low aborts to IDLE on next edge
//   core_state                : core pipeline state (REQUEST / UPDATE used)
//   decoded_mem_read_enable   : instruction is LDR
//   decoded_mem_write_enable  : instruction is STR
//   rs, rt                    : address operand, store data operand
//   mem_read_*  / mem_write_* : memory controller request/accept channels
//   lsu_state                 : IDLE/REQUESTING/WAITING/DONE/ERROR
//   lsu_out                   : last loaded data
//   lsu_error                 : last op failed (rd+wr conflict or timeout)
// Build option: define LSU_TIMEOUT_EN to abort WAITING after TIMEOUT_CYCLES
// cycles without ready.
module lsu_param
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [2:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("lsu_param: TIMEOUT_CYCLES must be >= 1");
  end

  lsu_state_t           state, state_nxt;
  logic                 is_read;     // op type, fixed when leaving IDLE
  logic [ADDR_BITS-1:0] addr_q;      // shared by both channels
  logic [DATA_BITS-1:0] wdata_q;
  logic [ADDR_BITS-1:0] addr_d;
  logic                 ready_hit;
  logic                 timeout;

  // rs zero-extended or truncated to the address width
  if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
    assign addr_d = rs[ADDR_BITS-1:0];
  end else begin : g_addr_ext
    assign addr_d = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
  end

  assign ready_hit = is_read ? mem_read_ready : mem_write_ready;

`ifdef LSU_TIMEOUT_EN
  lsu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == LSU_REQUESTING),
    .tick    (state == LSU_WAITING && !ready_hit),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LSU_IDLE;
    else        state <= state_nxt;
  end

  // next-state
  always_comb begin
    state_nxt = state;
    unique case (state)
      LSU_IDLE: begin
        if (enable && core_state == CORE_STATE_REQUEST) begin
          if (decoded_mem_read_enable && decoded_mem_write_enable)
            state_nxt = LSU_ERROR;
          else if (decoded_mem_read_enable || decoded_mem_write_enable)
            state_nxt = LSU_REQUESTING;
        end
      end
      LSU_REQUESTING: state_nxt = LSU_WAITING;
      LSU_WAITING: begin
        // ready beats a timeout on the same edge
        if (ready_hit)    state_nxt = LSU_DONE;
        else if (timeout) state_nxt = LSU_ERROR;
      end
      LSU_DONE, LSU_ERROR: begin
        if (core_state == CORE_STATE_UPDATE) state_nxt = LSU_IDLE;
      end
      default: state_nxt = LSU_IDLE;
    endcase
    if (!enable) state_nxt = LSU_IDLE;
  end

  // request/result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_read <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lsu_out <= '0;
    end else if (enable) begin
      if (state == LSU_IDLE && state_nxt == LSU_REQUESTING)
        is_read <= decoded_mem_read_enable;
      if (state == LSU_REQUESTING) begin
        addr_q <= addr_d;
        if (!is_read) wdata_q <= rt;
      end
      if (state == LSU_WAITING && is_read && mem_read_ready)
        lsu_out <= mem_read_data;
    end
  end

  // outputs: valid is exactly "in WAITING", so it drops on the accept edge
  always_comb begin
    mem_read_valid  = (state == LSU_WAITING) &&  is_read;
    mem_write_valid = (state == LSU_WAITING) && !is_read;
    lsu_error       = (state == LSU_ERROR);
    lsu_state       = state;
  end

  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;

endmodule

// File: tb/tb_lsu_param.sv
module tb_lsu_param;

  localparam logic [2:0] REQ = 3'b011;
  localparam logic [2:0] UPD = 3'b110;
  localparam logic [2:0] OTH = 3'b000;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       rd_en, wr_en;
  logic [7:0] rs, rt;
  logic       mem_read_valid, mem_read_ready;
  logic [7:0] mem_read_address, mem_read_data;
  logic       mem_write_valid, mem_write_ready;
  logic [7:0] mem_write_address, mem_write_data;
  logic [2:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_param #(.DATA_BITS(8), .ADDR_BITS(8), .TIMEOUT_CYCLES(4)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .mem_read_valid           (mem_read_valid),
    .mem_read_address         (mem_read_address),
    .mem_read_ready           (mem_read_ready),
    .mem_read_data            (mem_read_data),
    .mem_write_valid          (mem_write_valid),
    .mem_write_address        (mem_write_address),
    .mem_write_data           (mem_write_data),
    .mem_write_ready          (mem_write_ready),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out),
    .lsu_error                (lsu_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue a request at REQUEST, leave core in a neutral state afterwards
  task automatic issue(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    enable = 1'b1; core_state = REQ; rd_en = r; wr_en = w; rs = a; rt = d;
    tick();
    core_state = OTH;
  endtask

  task automatic retire();
    core_state = UPD;
    tick();
    core_state = OTH;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; core_state = OTH; rd_en = 1'b0; wr_en = 1'b0;
    rs = '0; rt = '0; mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
    #12;
    chk("rst_state", 32'(lsu_state), 32'd0);
    chk("rst_out",   32'({mem_read_valid, mem_write_valid, lsu_error, lsu_out}), 32'd0);
    reset = 1'b1;
    tick();

    // 1: LDR, ready two cycles after valid
    issue(1'b1, 1'b0, 8'h2A, 8'h00);
    chk("ld_reqing", 32'(lsu_state), 32'd1);
    chk("ld_noval",  32'(mem_read_valid), 32'd0);
    rd_en = 1'b0;                       // mid-op change must be ignored
    tick();
    chk("ld_wait",   32'(lsu_state), 32'd2);
    chk("ld_val",    32'({mem_read_valid, mem_write_valid}), 32'b10);
    chk("ld_addr",   32'(mem_read_address), 32'h2A);
    tick();
    chk("ld_hold_v", 32'(mem_read_valid), 32'd1);
    chk("ld_hold_a", 32'(mem_read_address), 32'h2A);
    mem_read_ready = 1'b1; mem_read_data = 8'h5C;
    tick();
    mem_read_ready = 1'b0; mem_read_data = 8'h00;
    chk("ld_done",   32'(lsu_state), 32'd3);
    chk("ld_out",    32'(lsu_out), 32'h5C);
    chk("ld_vdrop",  32'(mem_read_valid), 32'd0);
    tick();
    chk("ld_dhold",  32'(lsu_state), 32'd3);
    retire();
    chk("ld_idle",   32'(lsu_state), 32'd0);

    // 2: STR, ready held high from the start
    mem_write_ready = 1'b1;
    issue(1'b0, 1'b1, 8'h10, 8'hA5);
    chk("st_reqing", 32'({lsu_state, mem_write_valid}), 32'({3'd1, 1'b0}));
    tick();
    chk("st_val",    32'({mem_read_valid, mem_write_valid}), 32'b01);
    chk("st_addr",   32'(mem_write_address), 32'h10);
    chk("st_data",   32'(mem_write_data), 32'hA5);
    tick();
    chk("st_done",   32'(lsu_state), 32'd3);
    chk("st_vdrop",  32'(mem_write_valid), 32'd0);
    chk("st_ldout",  32'(lsu_out), 32'h5C);
    mem_write_ready = 1'b0;
    retire();
    chk("st_idle",   32'(lsu_state), 32'd0);

    // 3: rd+wr conflict
    issue(1'b1, 1'b1, 8'h77, 8'h11);
    chk("cf_err",    32'({lsu_state, lsu_error}), 32'({3'd4, 1'b1}));
    chk("cf_noval",  32'({mem_read_valid, mem_write_valid}), 32'd0);
    rd_en = 1'b0; wr_en = 1'b0;
    tick();
    chk("cf_sticky", 32'({lsu_state, lsu_error, mem_read_valid, mem_write_valid}), 32'({3'd4, 3'b100}));
    retire();
    chk("cf_clear",  32'({lsu_state, lsu_error}), 32'd0);

    // 4: abort in WAITING, late ready ignored
    issue(1'b1, 1'b0, 8'h33, 8'h00);
    tick();
    chk("ab_wait",   32'(lsu_state), 32'd2);
    enable = 1'b0;
    tick();
    chk("ab_idle",   32'({lsu_state, mem_read_valid, lsu_error}), 32'd0);
    enable = 1'b1; mem_read_ready = 1'b1; mem_read_data = 8'hEE;
    tick();
    chk("ab_ign",    32'({lsu_state, lsu_out}), 32'({3'd0, 8'h5C}));
    mem_read_ready = 1'b0; mem_read_data = 8'h00;

    // 5: async reset between edges
    issue(1'b1, 1'b0, 8'h44, 8'h00);
    tick();
    chk("ar_wait",   32'(mem_read_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_state",  32'(lsu_state), 32'd0);
    chk("ar_outs",   32'({mem_read_valid, mem_read_address, lsu_out, lsu_error}), 32'd0);
    reset = 1'b1;
    tick();

`ifdef LSU_TIMEOUT_EN
    // 6a: ready never comes -> ERROR after the 4th WAITING cycle
    issue(1'b1, 1'b0, 8'h55, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("to_still",  32'({lsu_state, mem_read_valid}), 32'({3'd2, 1'b1}));
    tick();
    chk("to_err",    32'({lsu_state, lsu_error, mem_read_valid}), 32'({3'd4, 2'b10}));
    chk("to_out",    32'(lsu_out), 32'h00);
    retire();
    // 6b: ready on the 4th WAITING edge wins
    issue(1'b1, 1'b0, 8'h56, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) tick();
    mem_read_ready = 1'b1; mem_read_data = 8'h9D;
    tick();
    mem_read_ready = 1'b0;
    chk("to_race",   32'({lsu_state, lsu_error, lsu_out}), 32'({3'd3, 1'b0, 8'h9D}));
    retire();
`else
    // without the watchdog WAITING persists indefinitely
    issue(1'b1, 1'b0, 8'h55, 8'h00);
    for (int i = 0; i < 20; i++) tick();
    chk("nt_wait",   32'({lsu_state, mem_read_valid, lsu_error}), 32'({3'd2, 2'b10}));
    mem_read_ready = 1'b1; mem_read_data = 8'h9D;
    tick();
    mem_read_ready = 1'b0;
    chk("nt_done",   32'({lsu_state, lsu_out}), 32'({3'd3, 8'h9D}));
    retire();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
